// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
// The package holds the FSM state encoding, the ALU data width and the default watchdog limit.
package alu_arb_pkg;

  localparam int ALU_DW      = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_pick.sv
// alu_rr_pick: combinational round-robin picker.
// It searches from i_last+1 with wrap-around and returns a one-hot grant and its index.
module alu_rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic          w_found;
  logic [IW-1:0] w_k;

  // The last offset tried is i_last itself, so the previous winner has the lowest priority.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_k = IW'((int'(i_last) + off) % NREQ);
      if (!w_found && i_req[w_k]) begin
        w_found      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin front end that shares one multi-cycle ALU among NREQ requesters.
// Optional WAIT watchdog is enabled with `define ALU_ARB_TIMEOUT_EN.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = ALU_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_instr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic [DW-1:0]      alu_din,
  output logic               alu_run,
  input  logic               alu_done,
  input  logic [DW-1:0]      alu_g,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      r_state, w_next;
  logic [IW-1:0]   r_grant, r_last, w_idx;
  logic [NREQ-1:0] w_onehot;
  logic            w_any;
  logic [DW-1:0]   r_din, r_data;
  logic            w_timeout;

  alu_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_onehot),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A done arriving in the terminal WAIT cycle takes precedence over the watchdog.
  assign w_timeout = (r_state == WAIT) && !alu_done && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (r_state == WAIT) begin
      if (alu_done) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (alu_done || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // alu_din is loaded only when leaving IDLE, so it stays put from run through done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_din   <= '0;
      r_grant <= '0;
      r_last  <= IW'(NREQ - 1);
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_din   <= req_instr[int'(w_idx)*DW +: DW];
            r_grant <= w_idx;
          end
        end
        WAIT: begin
          if (alu_done) begin
            r_data <= alu_g;
          end else if (w_timeout) begin
            r_data <= '0;
          end
        end
        RESP:    r_last <= r_grant;
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_onehot : '0;
  assign alu_run   = (r_state == ISSUE);
  assign rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_grant) : '0;
  assign rsp_data  = r_data;
  assign alu_din   = r_din;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter with an ALU model that raises done 3 cycles after run.
// Build with `define ALU_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT = 8).
module tb_alu_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int ALU_L = 3;
  localparam int LAT   = 3 + ALU_L;

  typedef struct {
    logic [NREQ-1:0]    valid;
    logic [NREQ*DW-1:0] instr;
    logic [NREQ-1:0]    expReady;
    logic [DW-1:0]      expData;
  } vec_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_instr = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [DW-1:0]      alu_din;
  logic               alu_run;
  logic               alu_done;
  logic [DW-1:0]      alu_g;
  logic               busy;

  logic [2:0]    mDly;
  logic [DW-1:0] mOp;
  logic          stray = 1'b0;
  logic          mute  = 1'b0;

  int passCount  = 0;
  int totalCount = 0;

  vec_t vecs [6];

  alu_req_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_instr (req_instr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_din   (alu_din),
    .alu_run   (alu_run),
    .alu_done  (alu_done),
    .alu_g     (alu_g),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ALU model: latches DIN on run, result is DIN ^ A5A5, done 3 cycles after run.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mDly <= '0;
      mOp  <= '0;
    end else begin
      mDly <= {mDly[1:0], alu_run};
      if (alu_run) mOp <= alu_din;
    end
  end

  assign alu_done = (mDly[2] & ~mute) | stray;
  assign alu_g    = mOp ^ 16'hA5A5;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One full transaction: request, accept, then follow it to its response.
  task automatic applyStimulus(input vec_t v, input logic strayOn, input int expLat,
                               input logic expErr, input string name);
    logic [DW-1:0]   expDin;
    logic [NREQ-1:0] gotValid;
    logic [DW-1:0]   gotData;
    logic            gotErr;
    int cyc, runs, dinBad;
    logic got;
    expDin = '0;
    for (int i = 0; i < NREQ; i++) if (v.expReady[i]) expDin = v.instr[i*DW +: DW];
    @(posedge clk); #1;
    req_valid = v.valid;
    req_instr = v.instr;
    @(negedge clk);
    checkOutput({name, "_ready"}, 64'(req_ready), 64'(v.expReady));
    @(posedge clk); #1;
    req_valid = '0;
    req_instr = ~v.instr;
    stray = strayOn;
    cyc = 1; runs = 0; dinBad = 0; got = 1'b0;
    gotValid = '0; gotData = '0; gotErr = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (alu_run) runs++;
      if (alu_din !== expDin) dinBad++;
      if (rsp_valid != '0) begin
        got = 1'b1;
        gotValid = rsp_valid;
        gotData  = rsp_data;
        gotErr   = rsp_err;
      end else begin
        @(posedge clk); #1;
        stray = 1'b0;
      end
    end
    stray = 1'b0;
    checkOutput({name, "_gotRsp"}, 64'(got), 64'(1'b1));
    checkOutput({name, "_rspValid"}, 64'(gotValid), 64'(v.expReady));
    checkOutput({name, "_rspData"}, 64'(gotData), 64'(v.expData));
    checkOutput({name, "_rspErr"}, 64'(gotErr), 64'(expErr));
    checkOutput({name, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({name, "_runCount"}, 64'(runs), 64'(1));
    checkOutput({name, "_dinStable"}, 64'(dinBad), 64'(0));
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] expR;
    int grants, resps, overlap, lateRsp;

    vecs[0] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0101}, 4'b0001, 16'hA4A4};
    vecs[1] = '{4'b1111, {16'h3333, 16'h2222, 16'h1111, 16'h0000}, 4'b0010, 16'hB4B4};
    vecs[2] = '{4'b1001, {16'h3333, 16'h2222, 16'h1111, 16'h0000}, 4'b1000, 16'h9696};
    vecs[3] = '{4'b0110, {16'h0000, 16'h2222, 16'h0F0F, 16'h0000}, 4'b0010, 16'hAAAA};
    vecs[4] = '{4'b0101, {16'h0000, 16'hE733, 16'h0F0F, 16'h0000}, 4'b0100, 16'h4296};
    vecs[5] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 4'b0001, 16'h5A5A};

    #2;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_din", 64'(alu_din), 64'(0));
    checkOutput("reset_run", 64'(alu_run), 64'(0));
    checkOutput("reset_rsp", 64'({rsp_valid, rsp_data, rsp_err, req_ready}), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0, LAT, 1'b0, $sformatf("vec%0d", i));

    // Fairness from reset: all four held valid, eight grants in rotation.
    doReset();
    req_valid = 4'b1111;
    req_instr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    grants = 0; resps = 0; overlap = 0;
    for (int c = 0; c < 200 && resps < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        expR = 4'b0001 << (grants % 4);
        checkOutput($sformatf("fairGrant%0d", grants), 64'(req_ready), 64'(expR));
        grants++;
      end
      if ($countones(rsp_valid) > 1) overlap++;
      if (rsp_valid != '0) resps++;
      @(posedge clk); #1;
      if (grants >= 8) req_valid = '0;
    end
    checkOutput("fairResps", 64'(resps), 64'(8));
    checkOutput("fairOverlap", 64'(overlap), 64'(0));

    applyStimulus('{4'b0100, {16'h0000, 16'hE733, 16'h0000, 16'h0000}, 4'b0100, 16'h4296},
                  1'b0, LAT, 1'b0, "stableDin");

    applyStimulus('{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0F0F}, 4'b0001, 16'hAAAA},
                  1'b1, LAT, 1'b0, "strayDone");

    // Reset during WAIT: last grant is 1 when reset hits, so without reset 2 would win next.
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_instr = {16'h0000, 16'h0000, 16'h1111, 16'h0000};
    @(negedge clk);
    checkOutput("midRst_ready", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checkOutput("midRst_busy", 64'(busy), 64'(0));
    checkOutput("midRst_din", 64'(alu_din), 64'(0));
    checkOutput("midRst_data", 64'(rsp_data), 64'(0));
    checkOutput("midRst_strobes", 64'({alu_run, rsp_valid, req_ready}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    lateRsp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) lateRsp++;
    end
    checkOutput("midRst_noRsp", 64'(lateRsp), 64'(0));
    applyStimulus('{4'b1111, {16'h3333, 16'h2222, 16'h1111, 16'h0101}, 4'b0001, 16'hA4A4},
                  1'b0, LAT, 1'b0, "afterRst");

`ifdef ALU_ARB_TIMEOUT_EN
    mute = 1'b1;
    applyStimulus('{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1234}, 4'b0001, 16'h0000},
                  1'b0, 2 + 8 + 1, 1'b1, "timeout");
    mute = 1'b0;
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
